// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V byte/half/word accesses into accesses on a
// word-only data memory, with read-modify-write for SB/SH.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we, funct3      store select and access size/sign (000 B .. 101 HU)
//   addr, wdata         byte address and store data
//   rdata, done, err    extended load result, completion pulse, reject flag
//   mem_addr            word index into data memory
//   mem_wdata, mem_rw   write word and write strobe (1 = write this cycle)
//   mem_rdata           combinational memory read data
module load_store_unit #(
  parameter int unsigned MEM_DEPTH = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    DONE,
    ERR
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        legal;

  // Replace the addressed byte/half of w with the low bits of d.
  // Any other size writes the whole word.
  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [31:0] d,
    input logic [2:0]  f,
    input logic [1:0]  o
  );
    logic [31:0] r;
    r = w;
    unique case (f[1:0])
      2'b00:   r[{o, 3'b000} +: 8] = d[7:0];
      2'b01:   r[{o[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [2:0]  f,
    input logic [1:0]  o
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{o, 3'b000} +: 8];
    h = w[{o[1], 4'b0000} +: 16];
    case (f)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      3'b100:  legal = ~req_we;
      3'b101:  legal = ~req_we & ~addr[0];
      default: legal = 1'b0;
    endcase
    if ({2'b00, addr[31:2]} >= MEM_DEPTH)
      legal = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = funct3;
          addr_d   = addr;
          wdata_d  = wdata;
          if (!legal) begin
            state_d = ERR;
          end else if (req_we && funct3 == 3'b010) begin
            // full-word store needs no read
            state_d     = WR;
            mem_wdata_d = wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        word_d = mem_rdata;
        if (we_q) begin
          state_d     = WR;
          mem_wdata_d = merge(word_d, wdata_q, funct3_q, addr_q[1:0]);
        end else begin
          state_d = DONE;
          rdata_d = extract(word_d, funct3_q, addr_q[1:0]);
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      word_q      <= 32'h0;
      rdata_q     <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign done      = (state_q == DONE) || (state_q == ERR);
  assign err       = (state_q == ERR);
  assign rdata     = rdata_q;
  assign mem_addr  = {2'b00, addr_q[31:2]};
  assign mem_wdata = mem_wdata_q;
  // gated by rst so a reset edge can never commit a write
  assign mem_rw    = (state_q == WR) && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory, directed cases and random
// traffic checked against a byte-level reference memory.
module tb_load_store_unit;

  localparam int DEPTH = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  logic [31:0] dmem [0:DEPTH-1];
  logic [31:0] rmem [0:DEPTH-1];
  logic        pl_en;
  int          pl_idx;
  logic [31:0] pl_val;

  int checks = 0;
  int passed = 0;
  int fails = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_rd;

  int   last_lat;
  int   last_rw;
  logic last_rw_first;
  logic        nxt_valid;
  logic        nxt_we;
  logic [2:0]  nxt_f3;
  logic [31:0] nxt_addr;
  logic [31:0] nxt_wdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rw    (mem_rw),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32'(DEPTH)) ? dmem[mem_addr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_rw) begin
      if (mem_addr < 32'(DEPTH)) dmem[mem_addr[6:0]] <= mem_wdata;
    end else if (pl_en) begin
      dmem[pl_idx] <= pl_val;
    end
  end

  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input bit we, input bit [2:0] f,
                                   input bit [31:0] a);
    if (f == 3 || f >= 6) return 0;
    if (we && f >= 4) return 0;
    if ((f == 1 || f == 5) && a % 2 != 0) return 0;
    if (f == 2 && a % 4 != 0) return 0;
    if (a / 4 >= DEPTH) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input bit [2:0] f,
                                           input bit [31:0] a);
    logic [31:0] w, v;
    int sh;
    w  = rmem[int'(a >> 2)];
    sh = int'(a % 4) * 8;
    v  = w;
    if (f == 0 || f == 4) begin
      v = (w >> sh) & 32'hFF;
      if (f == 0 && v >= 128) v = v - 256;
    end else if (f == 1 || f == 5) begin
      v = (w >> sh) & 32'hFFFF;
      if (f == 1 && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  task automatic ref_store(input bit [2:0] f, input bit [31:0] a,
                           input bit [31:0] wd);
    logic [31:0] mask;
    int idx, sh;
    idx = int'(a >> 2);
    sh  = int'(a % 4) * 8;
    if (f == 0) mask = 32'hFF << sh;
    else if (f == 1) mask = 32'hFFFF << sh;
    else mask = 32'hFFFF_FFFF;
    rmem[idx] = (rmem[idx] & ~mask) | ((wd << sh) & mask);
  endtask

  function automatic int mem_diff();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++)
      if (dmem[i] !== rmem[i]) n++;
    return n;
  endfunction

  task automatic poke(input int idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(posedge clk); #1;
    pl_en  = 1'b0;
    rmem[idx] = val;
  endtask

  task automatic set_junk();
    nxt_valid = 1'b0;
    nxt_we    = 1'($urandom);
    nxt_f3    = 3'($urandom);
    nxt_addr  = $urandom;
    nxt_wdata = $urandom;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 10 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    check({tag, "/ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  // Accept on the next edge, then follow the op until done (bounded).
  task automatic do_op();
    @(posedge clk); #1;
    req_valid = nxt_valid;
    req_we    = nxt_we;
    funct3    = nxt_f3;
    addr      = nxt_addr;
    wdata     = nxt_wdata;
    last_lat  = 0;
    last_rw   = 0;
    last_rw_first = mem_rw;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (mem_rw) last_rw++;
      if (done) begin
        last_lat = k + 1;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input bit we, input bit [2:0] f,
                        input bit [31:0] a, input bit [31:0] wd);
    bit ok;
    int elat, erw;
    req_we    = we;
    funct3    = f;
    addr      = a;
    wdata     = wd;
    req_valid = 1'b1;
    wait_ready(tag);
    ok   = ref_legal(we, f, a);
    elat = !ok ? 1 : (we && f != 3'd2) ? 3 : 2;
    erw  = (ok && we) ? 1 : 0;
    if (ok && !we) exp_rd = ref_load(f, a);
    if (ok && we) ref_store(f, a, wd);
    do_op();
    check({tag, "/lat"}, last_lat, elat);
    check({tag, "/err"}, {31'b0, err}, {31'b0, !ok});
    check({tag, "/rw"}, last_rw, erw);
    check({tag, "/rdata"}, rdata, exp_rd);
    check({tag, "/mem"}, mem_diff(), 0);
    if (ok && we)
      check({tag, "/rw_first"}, {31'b0, last_rw_first}, {31'b0, f == 3'd2});
  endtask

  task automatic op(input string tag, input bit we, input bit [2:0] f,
                    input bit [31:0] a, input bit [31:0] wd);
    set_junk();
    run_op(tag, we, f, a, wd);
  endtask

  task automatic gen(output logic we, output logic [2:0] f,
                     output logic [31:0] a, output logic [31:0] wd);
    int k;
    we = 1'($urandom_range(0, 1));
    if (we) begin
      f = 3'($urandom_range(0, 2));
    end else begin
      k = $urandom_range(0, 4);
      f = (k < 3) ? 3'(k) : 3'(k + 1);
    end
    a = 32'($urandom_range(0, 7)) * 4;
    if (f == 1 || f == 5) a = a + 2 * 32'($urandom_range(0, 1));
    else if (f == 0 || f == 4) a = a + 32'($urandom_range(0, 3));
    wd = $urandom;
  endtask

  initial begin
    logic        cwe, nwe;
    logic [2:0]  cf, nf;
    logic [31:0] ca, na, cwd, nwd;
    int acc0, done0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    pl_en     = 1'b0;
    pl_idx    = 0;
    pl_val    = 32'h0;
    exp_rd    = 32'h0;
    nwe = 1'b0; nf = 3'b0; na = 32'h0; nwd = 32'h0;
    set_junk();
    for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
    rst = 1'b0;
    @(posedge clk); #1;

    check("reset/ready", {31'b0, req_ready}, 32'd1);
    check("reset/done", {31'b0, done}, 32'd0);
    check("reset/err", {31'b0, err}, 32'd0);
    check("reset/mem_rw", {31'b0, mem_rw}, 32'd0);
    check("reset/mem_wdata", mem_wdata, 32'h0);
    check("reset/rdata", rdata, 32'h0);
    check("reset/mem_addr", mem_addr, 32'h0);

    poke(0, 32'h8000_7F80);
    op("lb0", 0, 3'b000, 32'd0, 32'h0);
    check("lb0/const", rdata, 32'hFFFF_FF80);
    op("lbu0", 0, 3'b100, 32'd0, 32'h0);
    check("lbu0/const", rdata, 32'h0000_0080);
    op("lb1", 0, 3'b000, 32'd1, 32'h0);
    check("lb1/const", rdata, 32'h0000_007F);

    poke(1, 32'h1234_5678);
    op("sb6", 1, 3'b000, 32'd6, 32'h0000_00AB);
    check("sb6/word", dmem[1], 32'h12AB_5678);
    check("sb6/lat", last_lat, 3);
    check("sb6/rw_once", last_rw, 1);

    op("sw8", 1, 3'b010, 32'd8, 32'hDEAD_BEEF);
    check("sw8/word", dmem[2], 32'hDEAD_BEEF);
    check("sw8/lat", last_lat, 2);
    op("lhu10", 0, 3'b101, 32'd10, 32'h0);
    check("lhu10/const", rdata, 32'h0000_DEAD);

    op("lw2", 0, 3'b010, 32'd2, 32'h0);
    op("sh3", 1, 3'b001, 32'd3, 32'h1111_2222);
    op("f011", 0, 3'b011, 32'd0, 32'h0);
    op("sb_oor", 1, 3'b000, 32'(4 * DEPTH), 32'h55);
    op("sbu", 1, 3'b100, 32'd16, 32'h66);

    for (int i = 0; i < 10; i++) begin
      op("mix", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
         32'($urandom_range(0, 4 * DEPTH + 7)), $urandom);
    end

    wait_ready("rst");
    set_junk();
    req_valid = 1'b1;
    req_we    = 1'b1;
    funct3    = 3'b000;
    addr      = 32'd21;
    wdata     = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst/rd_rw", {31'b0, mem_rw}, 32'd0);
    @(posedge clk); #1;
    check("rst/wr_rw", {31'b0, mem_rw}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst/forced", {31'b0, mem_rw}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd = 32'h0;
    check("rst/ready", {31'b0, req_ready}, 32'd1);
    check("rst/done", {31'b0, done}, 32'd0);
    check("rst/mem", mem_diff(), 0);
    check("rst/rdata", rdata, 32'h0);
    @(posedge clk); #1;
    check("rst/done2", {31'b0, done}, 32'd0);

    acc0  = acc_cnt;
    done0 = done_cnt;
    gen(cwe, cf, ca, cwd);
    for (int i = 0; i < 20; i++) begin
      if (i < 19) begin
        gen(nwe, nf, na, nwd);
        nxt_valid = 1'b1;
        nxt_we    = nwe;
        nxt_f3    = nf;
        nxt_addr  = na;
        nxt_wdata = nwd;
      end else begin
        set_junk();
      end
      run_op("rnd", cwe, cf, ca, cwd);
      cwe = nwe;
      cf  = nf;
      ca  = na;
      cwd = nwd;
    end
    repeat (5) @(posedge clk);
    #1;
    check("rnd/accepts", acc_cnt - acc0, 20);
    check("rnd/dones", done_cnt - done0, 20);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
